// File: rtl/timer_4bit_seq_if.sv
// rtl/timer_4bit_seq_if.sv - request/status bundle between control logic and timer_4bit_seq
interface timer_4bit_seq_if;
  logic       start;
  logic [3:0] req_preset;
  logic       req_mode;
  logic [3:0] req_reps;
  logic       pause;
  logic       abort;
  logic       ready;
  logic       busy;
  logic       irq;
  logic       aborted;
  logic [3:0] intervals_done;

  modport master (
    output start, req_preset, req_mode, req_reps, pause, abort,
    input  ready, busy, irq, aborted, intervals_done
  );

  modport slave (
    input  start, req_preset, req_mode, req_reps, pause, abort,
    output ready, busy, irq, aborted, intervals_done
  );
endinterface

// File: rtl/timer_4bit_seq.sv
// rtl/timer_4bit_seq.sv - sequences repeated timer_4bit intervals from one start/ready request
module timer_4bit_seq (
  input  logic                 clk,
  input  logic                 reset,
  timer_4bit_seq_if.slave      req,
  output logic                 tmr_load,
  output logic                 tmr_enable,
  output logic                 tmr_mode,
  output logic [3:0]           tmr_preset,
  input  logic                 tmr_done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] preset_q, preset_d;
  logic       mode_q, mode_d;
  logic [3:0] reps_left_q, reps_left_d;
  logic [3:0] intervals_done_q, intervals_done_d;
  logic       aborted_q, aborted_d;
  logic       active;

  assign active = (state_q != ST_IDLE);

  always_comb begin
    state_d          = state_q;
    preset_d         = preset_q;
    mode_d           = mode_q;
    reps_left_d      = reps_left_q;
    intervals_done_d = intervals_done_q;
    aborted_d        = 1'b0;
    // abort outranks everything except reset and is a no-op in IDLE
    if (active && req.abort) begin
      state_d   = ST_IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req.start) begin
            preset_d         = req.req_preset;
            mode_d           = req.req_mode;
            reps_left_d      = (req.req_reps == 4'd0) ? 4'd1 : req.req_reps;
            intervals_done_d = 4'd0;
            state_d          = ST_LOAD;
          end
        end
        ST_LOAD: state_d = ST_RUN;
        ST_RUN: begin
          if (tmr_done) begin
            intervals_done_d = intervals_done_q + 4'd1;
            reps_left_d      = reps_left_q - 4'd1;
            state_d          = (reps_left_q == 4'd1) ? ST_FINISH : ST_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      preset_q         <= 4'd0;
      mode_q           <= 1'b0;
      reps_left_q      <= 4'd0;
      intervals_done_q <= 4'd0;
      aborted_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      preset_q         <= preset_d;
      mode_q           <= mode_d;
      reps_left_q      <= reps_left_d;
      intervals_done_q <= intervals_done_d;
      aborted_q        <= aborted_d;
    end
  end

  // abort gates the timer controls and irq in the very cycle it is seen
  assign req.ready          = (state_q == ST_IDLE);
  assign req.busy           = active;
  assign req.irq            = (state_q == ST_FINISH) && !req.abort;
  assign req.aborted        = aborted_q;
  assign req.intervals_done = intervals_done_q;

  assign tmr_load   = (state_q == ST_LOAD) && !req.abort;
  assign tmr_enable = (state_q == ST_RUN) && !req.abort && !req.pause && !tmr_done;
  assign tmr_mode   = mode_q;
  assign tmr_preset = preset_q;

endmodule

// File: tb/tb_timer_4bit_seq.sv
// tb/tb_timer_4bit_seq.sv - directed bench for timer_4bit_seq with a behavioural 4-bit timer
module tb_timer_4bit_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tmr_load, tmr_enable, tmr_mode, tmr_done;
  logic [3:0] tmr_preset;
  logic [3:0] t_cnt;

  timer_4bit_seq_if bus ();

  timer_4bit_seq dut (
    .clk        (clk),
    .reset      (rst_n),
    .req        (bus.slave),
    .tmr_load   (tmr_load),
    .tmr_enable (tmr_enable),
    .tmr_mode   (tmr_mode),
    .tmr_preset (tmr_preset),
    .tmr_done   (tmr_done)
  );

  always #5 clk = ~clk;

  // timer_4bit: registered done, cleared by load, enable ignored once done
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_cnt    <= 4'd0;
      tmr_done <= 1'b0;
    end else if (tmr_load) begin
      t_cnt    <= tmr_preset;
      tmr_done <= 1'b0;
    end else if (tmr_enable && !tmr_done) begin
      if (tmr_mode ? (t_cnt == 4'd0) : (t_cnt == 4'd15)) tmr_done <= 1'b1;
      else t_cnt <= tmr_mode ? t_cnt - 4'd1 : t_cnt + 4'd1;
    end
  end

  int total = 0;
  int bad = 0;
  int cyc, irq_cnt, irq_cyc, load_cnt, ab_cnt, ab_cyc, ready_cyc, en_viol;
  int load_cyc [0:7];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.irq) begin irq_cnt++; irq_cyc = cyc; end
      if (tmr_load) begin
        if (load_cnt < 8) load_cyc[load_cnt] = cyc;
        load_cnt++;
      end
      if (bus.aborted) begin ab_cnt++; ab_cyc = cyc; end
      if (bus.ready && cyc > 0 && ready_cyc < 0) ready_cyc = cyc;
      if ((bus.pause || bus.abort) && tmr_enable) en_viol++;
      if (bus.abort && bus.busy && tmr_load) en_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] p, input logic m, input logic [3:0] r);
    @(posedge clk); #1;
    cyc = 0; irq_cnt = 0; irq_cyc = -1; load_cnt = 0; ab_cnt = 0; ab_cyc = -1;
    ready_cyc = -1; en_viol = 0;
    for (int i = 0; i < 8; i++) load_cyc[i] = -1;
    bus.start = 1'b1; bus.req_preset = p; bus.req_mode = m; bus.req_reps = r;
  endtask

  task automatic run(input int n, input int plo, input int phi, input int acyc);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = (cyc == acyc);
      bus.abort = (cyc == acyc);
      bus.pause = (cyc >= plo) && (cyc <= phi);
    end
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_ready"}, bus.ready, 1);
    chk({pfx, "_busy"}, bus.busy, 0);
    chk({pfx, "_irq"}, bus.irq, 0);
    chk({pfx, "_aborted"}, bus.aborted, 0);
    chk({pfx, "_idone"}, bus.intervals_done, 0);
    chk({pfx, "_load"}, tmr_load, 0);
    chk({pfx, "_enable"}, tmr_enable, 0);
    chk({pfx, "_mode"}, tmr_mode, 0);
    chk({pfx, "_preset"}, tmr_preset, 0);
  endtask

  initial begin
    bus.start = 0; bus.req_preset = 0; bus.req_mode = 0; bus.req_reps = 0;
    bus.pause = 0; bus.abort = 0;
    cyc = 0;
    repeat (3) @(posedge clk);
    #1 chk_reset_values("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // countdown P=3, one rep
    launch(4'd3, 1'b1, 4'd1);
    run(10, -1, -1, -1);
    chk("cd3_load_cyc", load_cyc[0], 1);
    chk("cd3_irq_cyc", irq_cyc, 7);
    chk("cd3_irq_cnt", irq_cnt, 1);
    chk("cd3_ready_cyc", ready_cyc, 8);
    chk("cd3_idone", bus.intervals_done, 1);
    chk("cd3_mode_hold", tmr_mode, 1);
    chk("cd3_preset_hold", tmr_preset, 3);

    // count-up P=14, three reps back to back
    launch(4'd14, 1'b0, 4'd3);
    run(16, -1, -1, -1);
    chk("up14_load_cnt", load_cnt, 3);
    chk("up14_load0", load_cyc[0], 1);
    chk("up14_load1", load_cyc[1], 5);
    chk("up14_load2", load_cyc[2], 9);
    chk("up14_irq_cyc", irq_cyc, 13);
    chk("up14_irq_cnt", irq_cnt, 1);
    chk("up14_idone", bus.intervals_done, 3);

    // reps=0 treated as one rep
    launch(4'd0, 1'b1, 4'd0);
    run(7, -1, -1, -1);
    chk("r0_irq_cyc", irq_cyc, 4);
    chk("r0_load_cnt", load_cnt, 1);
    chk("r0_idone", bus.intervals_done, 1);

    // countdown P=5 with pause over cycles 4..7
    launch(4'd5, 1'b1, 4'd1);
    run(16, 4, 7, -1);
    chk("pause_irq_cyc", irq_cyc, 13);
    chk("pause_ready_cyc", ready_cyc, 14);
    chk("pause_en_low", en_viol, 0);
    chk("pause_idone", bus.intervals_done, 1);

    // abort in RUN of rep 2 of 4, start in the same cycle ignored
    launch(4'd1, 1'b1, 4'd4);
    run(12, -1, -1, 7);
    chk("ab_aborted_cnt", ab_cnt, 1);
    chk("ab_aborted_cyc", ab_cyc, 8);
    chk("ab_irq_cnt", irq_cnt, 0);
    chk("ab_idone", bus.intervals_done, 1);
    chk("ab_ready_cyc", ready_cyc, 8);
    chk("ab_load_cnt", load_cnt, 2);
    chk("ab_ctrl_low", en_viol, 0);
    chk("ab_busy_after", bus.busy, 0);

    // asynchronous reset mid-RUN, then a fresh two-rep request
    launch(4'd9, 1'b1, 4'd1);
    run(4, -1, -1, -1);
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_values("arst");
    @(posedge clk); #3 rst_n = 1'b1;
    launch(4'd2, 1'b1, 4'd2);
    run(13, -1, -1, -1);
    chk("post_load_cnt", load_cnt, 2);
    chk("post_load1", load_cyc[1], 6);
    chk("post_irq_cyc", irq_cyc, 11);
    chk("post_idone", bus.intervals_done, 2);
    chk("post_aborted", ab_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
